// File: rtl/xc_malu_seq_if.sv
// xc_malu_seq_if: issue-side request/response channel plus flush for the
// multiply/divide/remainder sequencer.
interface xc_malu_seq_if;
  logic        req_valid;
  logic        req_ready;
  logic [9:0]  req_op;
  logic [4:0]  req_pw;
  logic [31:0] req_rs1;
  logic [31:0] req_rs2;
  logic [31:0] req_rs3;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [63:0] rsp_result;
  logic        rsp_err;
  logic        flush;

  modport master (
    output req_valid, req_op, req_pw, req_rs1, req_rs2, req_rs3, rsp_ready, flush,
    input  req_ready, rsp_valid, rsp_result, rsp_err
  );

  modport slave (
    input  req_valid, req_op, req_pw, req_rs1, req_rs2, req_rs3, rsp_ready, flush,
    output req_ready, rsp_valid, rsp_result, rsp_err
  );
endinterface

// File: rtl/xc_malu_seq.sv
// xc_malu_seq: IDLE/RUN/DONE sequencer owning the iteration state of the
// multi-cycle mul/div/rem datapath. Define XC_MALU_SEQ_CACHE_EN for a one-entry result cache.
module xc_malu_seq #(
  parameter int unsigned MAX_COUNT = 63
) (
  input  logic               clock,
  input  logic               reset,
  xc_malu_seq_if.slave       bus,
  output logic               dp_valid,
  output logic               dp_flush,
  output logic               dp_do_pclmul,
  output logic               dp_do_pmul,
  output logic               dp_do_clmul,
  output logic               dp_do_mulsu,
  output logic               dp_do_mulu,
  output logic               dp_do_mul,
  output logic               dp_do_remu,
  output logic               dp_do_rem,
  output logic               dp_do_divu,
  output logic               dp_do_div,
  output logic               dp_pw_2,
  output logic               dp_pw_4,
  output logic               dp_pw_8,
  output logic               dp_pw_16,
  output logic               dp_pw_32,
  output logic [31:0]        dp_rs1,
  output logic [31:0]        dp_rs2,
  output logic [31:0]        dp_rs3,
  output logic [5:0]         dp_count,
  output logic [63:0]        dp_acc,
  output logic [31:0]        dp_arg_0,
  output logic [31:0]        dp_arg_1,
  input  logic [63:0]        dp_n_acc,
  input  logic [31:0]        dp_n_arg_0,
  input  logic [31:0]        dp_n_arg_1,
  input  logic [63:0]        dp_result,
  input  logic               dp_ready
);

  localparam int unsigned OP_W  = 10;
  localparam int unsigned PW_W  = 5;
  localparam int unsigned CNT_W = 6;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t            state;
  logic [OP_W-1:0]   do_q;
  logic [PW_W-1:0]   pw_q;
  logic              req_ready_q;
  logic              rsp_valid_q;
  logic              rsp_err_q;
  logic [63:0]       rsp_result_q;
  logic              op_legal;
  logic              div_class;
  logic              watchdog;

  assign op_legal  = (bus.req_op != '0) && ((bus.req_op & (bus.req_op - OP_W'(1))) == '0);
  assign div_class = |bus.req_op[3:0];
  assign watchdog  = (dp_count == CNT_W'(MAX_COUNT));

  assign bus.req_ready  = req_ready_q;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_err    = rsp_err_q;
  assign bus.rsp_result = rsp_result_q;

  assign {dp_do_pclmul, dp_do_pmul, dp_do_clmul, dp_do_mulsu, dp_do_mulu,
          dp_do_mul, dp_do_remu, dp_do_rem, dp_do_divu, dp_do_div} = do_q;
  assign {dp_pw_2, dp_pw_4, dp_pw_8, dp_pw_16, dp_pw_32} = pw_q;

`ifdef XC_MALU_SEQ_CACHE_EN
  logic              cache_valid;
  logic [OP_W-1:0]   cache_op;
  logic [PW_W-1:0]   cache_pw;
  logic [31:0]       cache_rs1;
  logic [31:0]       cache_rs2;
  logic [31:0]       cache_rs3;
  logic [63:0]       cache_result;
  logic              cache_hit;

  assign cache_hit = cache_valid && (cache_op == bus.req_op) && (cache_pw == bus.req_pw) &&
                     (cache_rs1 == bus.req_rs1) && (cache_rs2 == bus.req_rs2) &&
                     (cache_rs3 == bus.req_rs3);

  // Filled on every successful RUN completion; only reset invalidates it.
  always_ff @(posedge clock) begin
    if (reset) begin
      cache_valid  <= 1'b0;
      cache_op     <= '0;
      cache_pw     <= '0;
      cache_rs1    <= '0;
      cache_rs2    <= '0;
      cache_rs3    <= '0;
      cache_result <= '0;
    end else if (!bus.flush && (state == RUN) && dp_ready) begin
      cache_valid  <= 1'b1;
      cache_op     <= do_q;
      cache_pw     <= pw_q;
      cache_rs1    <= dp_rs1;
      cache_rs2    <= dp_rs2;
      cache_rs3    <= dp_rs3;
      cache_result <= dp_result;
    end
  end
`endif

  // Sequencer FSM; flush overrides every other event in the same cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= IDLE;
      req_ready_q  <= 1'b1;
      rsp_valid_q  <= 1'b0;
      rsp_err_q    <= 1'b0;
      rsp_result_q <= '0;
      dp_valid     <= 1'b0;
      dp_flush     <= 1'b0;
      do_q         <= '0;
      pw_q         <= '0;
      dp_rs1       <= '0;
      dp_rs2       <= '0;
      dp_rs3       <= '0;
      dp_count     <= '0;
      dp_acc       <= '0;
      dp_arg_0     <= '0;
      dp_arg_1     <= '0;
    end else if (bus.flush) begin
      state       <= IDLE;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      dp_valid    <= 1'b0;
      dp_flush    <= 1'b1;
      do_q        <= '0;
    end else begin
      dp_flush <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            pw_q        <= bus.req_pw;
            dp_rs1      <= bus.req_rs1;
            dp_rs2      <= bus.req_rs2;
            dp_rs3      <= bus.req_rs3;
            req_ready_q <= 1'b0;
            if (!op_legal) begin
              state        <= DONE;
              rsp_valid_q  <= 1'b1;
              rsp_err_q    <= 1'b1;
              rsp_result_q <= '0;
              do_q         <= '0;
            end
`ifdef XC_MALU_SEQ_CACHE_EN
            else if (cache_hit) begin
              state        <= DONE;
              rsp_valid_q  <= 1'b1;
              rsp_err_q    <= 1'b0;
              rsp_result_q <= cache_result;
              do_q         <= bus.req_op;
            end
`endif
            else begin
              state    <= RUN;
              dp_valid <= 1'b1;
              do_q     <= bus.req_op;
              dp_count <= '0;
              dp_acc   <= '0;
              dp_arg_1 <= '0;
              dp_arg_0 <= div_class ? bus.req_rs1 : bus.req_rs2;
            end
          end
        end
        RUN: begin
          if (dp_ready) begin
            state        <= DONE;
            dp_valid     <= 1'b0;
            rsp_valid_q  <= 1'b1;
            rsp_err_q    <= 1'b0;
            rsp_result_q <= dp_result;
          end else if (watchdog) begin
            state        <= DONE;
            dp_valid     <= 1'b0;
            rsp_valid_q  <= 1'b1;
            rsp_err_q    <= 1'b1;
            rsp_result_q <= '0;
          end else begin
            dp_count <= dp_count + CNT_W'(1);
            dp_acc   <= dp_n_acc;
            dp_arg_0 <= dp_n_arg_0;
            dp_arg_1 <= dp_n_arg_1;
          end
        end
        DONE: begin
          if (bus.rsp_ready) begin
            state       <= IDLE;
            rsp_valid_q <= 1'b0;
            req_ready_q <= 1'b1;
            do_q        <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_xc_malu_seq.sv
// tb_xc_malu_seq: directed plus randomized checks of xc_malu_seq against an
// arithmetic reference and a stand-in datapath with programmable step count.
module tb_xc_malu_seq;
  localparam int unsigned MAXC = 63;

  logic        clock;
  logic        reset;
  logic        dp_valid, dp_flush, dp_ready;
  logic [9:0]  dp_do;
  logic [4:0]  dp_pw;
  logic [31:0] dp_rs1, dp_rs2, dp_rs3, dp_arg_0, dp_arg_1, dp_n_arg_0, dp_n_arg_1;
  logic [5:0]  dp_count;
  logic [63:0] dp_acc, dp_n_acc, dp_result;

  logic [6:0]  lat;
  logic [63:0] cur_result;
  int          checks = 0;
  int          errors = 0;

  xc_malu_seq_if bus ();

  xc_malu_seq #(.MAX_COUNT(MAXC)) dut (
    .clock(clock), .reset(reset), .bus(bus),
    .dp_valid(dp_valid), .dp_flush(dp_flush),
    .dp_do_pclmul(dp_do[9]), .dp_do_pmul(dp_do[8]), .dp_do_clmul(dp_do[7]),
    .dp_do_mulsu(dp_do[6]), .dp_do_mulu(dp_do[5]), .dp_do_mul(dp_do[4]),
    .dp_do_remu(dp_do[3]), .dp_do_rem(dp_do[2]), .dp_do_divu(dp_do[1]), .dp_do_div(dp_do[0]),
    .dp_pw_2(dp_pw[4]), .dp_pw_4(dp_pw[3]), .dp_pw_8(dp_pw[2]), .dp_pw_16(dp_pw[1]), .dp_pw_32(dp_pw[0]),
    .dp_rs1(dp_rs1), .dp_rs2(dp_rs2), .dp_rs3(dp_rs3),
    .dp_count(dp_count), .dp_acc(dp_acc), .dp_arg_0(dp_arg_0), .dp_arg_1(dp_arg_1),
    .dp_n_acc(dp_n_acc), .dp_n_arg_0(dp_n_arg_0), .dp_n_arg_1(dp_n_arg_1),
    .dp_result(dp_result), .dp_ready(dp_ready)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Stand-in datapath: acc accumulates arg_0, arg_1 counts steps, ready after 'lat' steps.
  assign dp_ready   = dp_valid && ({1'b0, dp_count} == lat);
  assign dp_result  = cur_result;
  assign dp_n_acc   = dp_acc + {32'b0, dp_arg_0};
  assign dp_n_arg_0 = dp_arg_0;
  assign dp_n_arg_1 = dp_arg_1 + 32'd1;

  function automatic logic [63:0] ref_calc(input logic [9:0] op, input logic [31:0] a, b, c);
    logic [63:0] r;
    logic signed [63:0] sa, sb;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    r  = '0;
    if (op[0]) begin
      if (b == 32'd0) r = 64'h0000_0000_FFFF_FFFF;
      else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = {32'b0, a};
      else r = {32'b0, 32'($signed(a) / $signed(b))};
    end else if (op[1]) begin
      r = (b == 32'd0) ? 64'h0000_0000_FFFF_FFFF : {32'b0, a / b};
    end else if (op[2]) begin
      if (b == 32'd0) r = {32'b0, a};
      else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = '0;
      else r = {32'b0, 32'($signed(a) % $signed(b))};
    end else if (op[3]) begin
      r = (b == 32'd0) ? {32'b0, a} : {32'b0, a % b};
    end else if (op[4]) begin
      r = 64'(sa * sb);
    end else if (op[5]) begin
      r = {32'b0, a} * {32'b0, b};
    end else if (op[6]) begin
      r = 64'(sa * $signed({32'b0, b}));
    end else if (op[7]) begin
      for (int i = 0; i < 32; i++) if (b[i]) r = r ^ ({32'b0, a} << i);
    end else begin
      r = {c, a ^ b};
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue one op from IDLE, wait for its response, check it, then drain it.
  task automatic run_op(input string tag, input logic [9:0] op, input logic [4:0] pw,
                        input logic [31:0] a, b, c, input logic [6:0] steps,
                        input int exp_lat, input logic exp_err, input int hold);
    logic [63:0] exp_res;
    logic [31:0] exp_arg0;
    int cyc, runs;
    exp_res    = exp_err ? 64'd0 : ref_calc(op, a, b, c);
    exp_arg0   = (|op[3:0]) ? a : b;
    cur_result = ref_calc(op, a, b, c);
    lat        = steps;
    chk({tag, "_idle_ready"}, 64'(bus.req_ready), 64'd1);
    chk({tag, "_idle_do"}, 64'(dp_do), 64'd0);
    bus.req_valid = 1'b1; bus.req_op = op; bus.req_pw = pw;
    bus.req_rs1 = a; bus.req_rs2 = b; bus.req_rs3 = c;
    @(negedge clock);
    bus.req_valid = 1'b0;
    cyc = 1; runs = 0;
    while (!bus.rsp_valid && cyc < 200) begin
      if (dp_valid) begin
        runs++;
        if (dp_ready) begin
          chk({tag, "_acc"}, dp_acc, 64'(steps) * {32'b0, exp_arg0});
          chk({tag, "_arg0"}, 64'(dp_arg_0), 64'(exp_arg0));
          chk({tag, "_arg1"}, 64'(dp_arg_1), 64'(steps));
          chk({tag, "_ops"}, {dp_rs1, dp_rs2 ^ dp_rs3}, {a, b ^ c});
          chk({tag, "_do_pw"}, 64'({dp_do, dp_pw}), 64'({op, pw}));
        end
      end
      @(negedge clock);
      cyc++;
    end
    chk({tag, "_latency"}, 64'(cyc), 64'(exp_lat));
    chk({tag, "_run_cycles"}, 64'(runs), 64'(exp_lat - 1));
    chk({tag, "_result"}, bus.rsp_result, exp_res);
    chk({tag, "_err"}, 64'(bus.rsp_err), 64'(exp_err));
    for (int i = 0; i < hold; i++) begin
      @(negedge clock);
      chk({tag, "_hold_valid"}, 64'({bus.rsp_valid, bus.req_ready}), 64'b10);
      chk({tag, "_hold_result"}, bus.rsp_result, exp_res);
    end
    bus.rsp_ready = 1'b1;
    @(negedge clock);
    bus.rsp_ready = 1'b0;
    chk({tag, "_drained"}, 64'({bus.rsp_valid, bus.req_ready}), 64'b01);
  endtask

  initial begin
    int cyc, seen;
    logic [9:0]  op;
    logic [4:0]  pw;
    logic [31:0] ra, rb, rc;
    int k, j;
    reset = 1'b1; lat = 7'd127; cur_result = '0;
    bus.req_valid = 1'b0; bus.req_op = '0; bus.req_pw = '0;
    bus.req_rs1 = '0; bus.req_rs2 = '0; bus.req_rs3 = '0;
    bus.rsp_ready = 1'b0; bus.flush = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b0;

    chk("rst_req_ready", 64'(bus.req_ready), 64'd1);
    chk("rst_rsp", {bus.rsp_result[61:0], bus.rsp_valid, bus.rsp_err}, 64'd0);
    chk("rst_dp_ctl", 64'({dp_valid, dp_flush, dp_do}), 64'd0);
    chk("rst_state_regs", dp_acc | {26'b0, dp_count, dp_arg_0 | dp_arg_1}, 64'd0);

    run_op("mulu_3x5", 10'h020, 5'b00001, 32'd3, 32'd5, 32'd0, 7'd32, 34, 1'b0, 5);
    run_op("div_neg", 10'h001, 5'b00001, 32'hFFFF_FFF9, 32'd2, 32'd0, 7'd20, 22, 1'b0, 0);
    run_op("fast", 10'h002, 5'b00010, 32'd100, 32'd7, 32'd1, 7'd0, 2, 1'b0, 0);

    // Flush while RUN is at count 10.
    lat = 7'd40; cur_result = ref_calc(10'h020, 32'd9, 32'd9, 32'd0);
    bus.req_valid = 1'b1; bus.req_op = 10'h020; bus.req_pw = 5'b00001;
    bus.req_rs1 = 32'd9; bus.req_rs2 = 32'd9; bus.req_rs3 = 32'd0;
    @(negedge clock);
    bus.req_valid = 1'b0;
    cyc = 0;
    while (dp_count != 6'd10 && cyc < 100) begin @(negedge clock); cyc++; end
    chk("flush_reach_cnt10", 64'(dp_count), 64'd10);
    bus.flush = 1'b1;
    @(negedge clock);
    bus.flush = 1'b0;
    chk("flush_pulse", 64'({dp_flush, bus.req_ready, dp_valid, bus.rsp_valid}), 64'b1100);
    chk("flush_do_gated", 64'(dp_do), 64'd0);
    seen = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      seen += int'(dp_flush) + int'(bus.rsp_valid) + int'(dp_valid);
    end
    chk("flush_quiet_after", 64'(seen), 64'd0);
    run_op("mulu_7x6", 10'h020, 5'b00001, 32'd7, 32'd6, 32'd0, 7'd32, 34, 1'b0, 0);

    // Flush in IDLE still pulses dp_flush.
    bus.flush = 1'b1;
    @(negedge clock);
    bus.flush = 1'b0;
    chk("flush_idle", 64'({dp_flush, bus.req_ready, bus.rsp_valid}), 64'b110);

    run_op("illegal_3", 10'h003, 5'b00001, 32'd1, 32'd2, 32'd3, 7'd5, 1, 1'b1, 2);
    run_op("illegal_0", 10'h000, 5'b00001, 32'd1, 32'd2, 32'd3, 7'd5, 1, 1'b1, 0);
    run_op("watchdog", 10'h040, 5'b00001, 32'd11, 32'd13, 32'd0, 7'd127, int'(MAXC) + 2, 1'b1, 1);

    // Reset in the middle of an operation.
    lat = 7'd40;
    bus.req_valid = 1'b1; bus.req_op = 10'h010; bus.req_rs1 = 32'd4; bus.req_rs2 = 32'd4;
    @(negedge clock);
    bus.req_valid = 1'b0;
    repeat (3) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    chk("midrst_idle", 64'({bus.req_ready, bus.rsp_valid, dp_valid, dp_flush}), 64'b1000);
    chk("midrst_count", 64'(dp_count), 64'd0);

    // Repeat of an identical op: cache hit when the cache is built in.
    run_op("cache_fill", 10'h020, 5'b00001, 32'd3, 32'd5, 32'd0, 7'd32, 34, 1'b0, 0);
`ifdef XC_MALU_SEQ_CACHE_EN
    run_op("cache_hit", 10'h020, 5'b00001, 32'd3, 32'd5, 32'd0, 7'd32, 1, 1'b0, 0);
`else
    run_op("cache_none", 10'h020, 5'b00001, 32'd3, 32'd5, 32'd0, 7'd32, 34, 1'b0, 0);
`endif
    run_op("cache_miss", 10'h020, 5'b00001, 32'd3, 32'd6, 32'd0, 7'd32, 34, 1'b0, 0);

    for (int n = 0; n < 16; n++) begin
      k  = int'($urandom_range(0, 9));
      pw = 5'(1) << $urandom_range(0, 4);
      ra = $urandom; rb = $urandom; rc = $urandom;
      if (n % 5 == 4) begin
        j  = (k + 1 + int'($urandom_range(0, 8))) % 10;
        op = (10'(1) << k) | (10'(1) << j);
        run_op("rand_illegal", op, pw, ra, rb, rc, 7'd3, 1, 1'b0 | 1'b1, 0);
      end else begin
        op  = 10'(1) << k;
        lat = 7'($urandom_range(0, 40));
        run_op("rand", op, pw, ra, rb, rc, lat, int'(lat) + 2, 1'b0, int'($urandom_range(0, 2)));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/xc_malu_seq.md
# xc_malu_seq

Sequencer for the multi-cycle multiply/divide/remainder datapath (xc_malu_muldivrem). It accepts one operation at a time over a valid/ready request channel and owns the iteration state registers (count, acc, arg_0, arg_1). It steps the datapath until it signals completion, then holds the 64-bit result on a valid/ready response channel. It sits between the instruction-issue logic and the datapath; the packed adder remains shared outside this block.

## Interface
Parameters:
- MAX_COUNT, 63: watchdog limit on count; hitting it without dp_ready ends the operation with an error.

Ports:
- clock  in  1  sole clock; all state on rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request.
- req_op  in  10  one-hot op {pclmul,pmul,clmul,mulsu,mulu,mul,remu,rem,divu,div} (bit 9..0).
- req_pw  in  5  one-hot packed width {pw_2,pw_4,pw_8,pw_16,pw_32} (bit 4..0).
- req_rs1, req_rs2, req_rs3  in  32 each  operands.
- rsp_valid  out  1  result present.
- rsp_ready  in  1  consumer takes result.
- rsp_result  out  64  result.
- rsp_err  out  1  illegal op or watchdog expiry.
- flush  in  1  abort in-flight operation.
- dp_valid, dp_flush  out  1 each  datapath controls.
- dp_do_*  out  10  decoded op strobes (gated to 0 in IDLE).
- dp_pw_*  out  5  latched width.
- dp_rs1/rs2/rs3  out  32  latched operands, stable for the whole operation.
- dp_count  out  6; dp_acc  out  64; dp_arg_0, dp_arg_1  out  32: current state registers.
- dp_n_acc  in  64; dp_n_arg_0, dp_n_arg_1  in  32; dp_result  in  64; dp_ready  in  1.

## Operation
- States: IDLE, RUN, DONE.
- IDLE: req_ready=1. On req_valid, latch op, pw and rs1-3.
  - Illegal op (req_op zero or multi-hot): go to DONE with rsp_err=1, result 0.
  - Legal op: load count=0, acc=0, arg_1=0. Load arg_0=rs1 for div-class ops, arg_0=rs2 otherwise. Go to RUN.
- RUN: dp_valid=1.
  - dp_ready=0: acc/arg_0/arg_1 take dp_n_*, and count increments by 1.
  - dp_ready=1: capture dp_result into rsp_result, rsp_err=0, go to DONE. State registers are not updated on this cycle.
  - count==MAX_COUNT and dp_ready=0: rsp_err=1, result 0, go to DONE.
- DONE: rsp_valid=1, and rsp_result/rsp_err hold stable. On rsp_ready go to IDLE. req_ready=0 in this state, so no same-cycle re-accept.
- flush, in any state:
  - Next state is IDLE, dp_flush=1 for that cycle, and rsp_valid is dropped.
  - flush has priority over accept, dp_ready and rsp_ready in the same cycle.
  - flush in IDLE is harmless and still pulses dp_flush.
- Count arithmetic is 6-bit. It never wraps because the watchdog fires first.

## Timing
- Reset values:
  - state=IDLE, req_ready=1.
  - rsp_valid=0, rsp_err=0, rsp_result=0.
  - dp_valid=0, dp_flush=0, all dp_do_*=0.
  - count=0, acc=0, arg_0=0, arg_1=0.
- Reset mid-operation behaves as flush, except dp_flush=0.
- Accept at cycle t:
  - RUN at t+1 with count=0.
  - If dp_ready is first high at t+k, rsp_valid rises at t+k+1.
  - Minimum latency is 2 cycles.
- Illegal op accepted at t: rsp_valid at t+1.
- Throughput: one operation per (latency + 1) cycles. IDLE always costs one cycle.
- rsp_valid held low→high→low only through rsp_ready or flush. Outputs are stable while stalled.

## Configuration
- XC_MALU_SEQ_CACHE_EN: when defined, adds a one-entry result cache.
  - Tags are op, pw and rs1-3. Stored data is the result.
  - On accept with a tag match and a valid entry, go directly to DONE with the cached result; rsp_valid at t+1.
  - The entry is filled on every non-error RUN completion.
  - The entry is invalidated by reset only. Flush keeps it. Error results are never cached.
- Undefined: no cache logic; every legal op enters RUN.

## Test plan
- Unsigned multiply: mulu, rs1=3, rs2=5, datapath model raises dp_ready after 32 steps → rsp_result=0x000000000000000F, rsp_err=0, rsp_valid 34 cycles after accept.
- Signed divide: div, rs1=0xFFFFFFF9, rs2=2 → rsp_result=0x00000000FFFFFFFD.
- Flush at RUN count=10 → dp_flush pulses once, IDLE the next cycle, no rsp_valid. A following mulu 7×6 returns 0x2A.
- Illegal op: req_op=0x003 → rsp_valid at t+1, rsp_err=1, result 0, dp_valid never asserted.
- Backpressure and watchdog:
  - Hold rsp_ready=0 for 5 cycles → result and rsp_valid stable, req_ready=0.
  - dp_ready tied 0 → rsp_err=1 after MAX_COUNT+1 RUN cycles.
- With XC_MALU_SEQ_CACHE_EN defined: repeat mulu 3×5 → second response at t+1 with 0xF and dp_valid never high. Change rs2 to 6 → full RUN, result 0x12.
